spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one `spi_master` parallel port between several requesters. Each requester submits a word and a target chip-select. The arbiter grants one requester at a time and issues the word to the master. It waits for the master's returned word, with a timeout, and routes the response back to the granted requester. It sits between the SPI client blocks and `spi_master`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 16, SPI word width, equal to the master's
- `CHIP_SELECT_SIZE`, 1, chip-select width, equal to the master's
- `TIMEOUT_CYCLES`, 1024, enabled cycles allowed from issue to response (≥2)

Ports:
- Clock and reset (already decided): `clk` is the clock; `rst_n` is the reset, asynchronous, active-low.
- `clk  in  1  clock`
- `rst_n  in  1  asynchronous active-low reset`
- `clk_en  in  1  global clock enable; all registers hold when 0`
- `req_valid  in  NUM_REQ  request pending, one bit per requester`
- `req_data  in  NUM_REQ*DATA_WIDTH  word per requester, requester i at [i*DATA_WIDTH +: DATA_WIDTH]`
- `req_cs  in  NUM_REQ*CHIP_SELECT_SIZE  chip-select pattern per requester, same packing`
- `req_ready  out  NUM_REQ  one-hot acceptance pulse`
- `resp_valid  out  NUM_REQ  one-hot response pulse`
- `resp_data  out  DATA_WIDTH  response word, shared by all requesters`
- `resp_err  out  1  response is a timeout`
- `m_data_in  out  DATA_WIDTH  to master data_in`
- `m_valid_data_in  out  1  to master valid_data_in`
- `m_ready  in  1  from master ready`
- `m_data_out  in  DATA_WIDTH  from master data_out`
- `m_valid_data_out  in  1  from master valid_data_out`
- `m_cs_sel  out  CHIP_SELECT_SIZE  chip-select pattern for the current transaction`
- `busy  out  1  state is not IDLE`
- `grant_id  out  $clog2(NUM_REQ)  index of the current or last grant`

## Operation
- All outputs are registered. State advances only on `clk_en=1`. With `clk_en=0`, outputs hold, so pulses stretch.
- FSM states are IDLE, ISSUE, WAIT_RESP and RESPOND.
- **IDLE**:
  - If any `req_valid` is set, grant the first set bit scanning from `(last_grant+1) mod NUM_REQ` upward, with wrap-around.
  - Latch the word into `m_data_in` and the chip-select into `m_cs_sel`.
  - Set `grant_id`, pulse `req_ready[g]` for one cycle, and set `m_valid_data_in=1`.
  - Clear the timer and go to ISSUE.
- **ISSUE**:
  - Hold `m_valid_data_in`.
  - When `m_ready=1`, drop `m_valid_data_in` and go to WAIT_RESP.
- **WAIT_RESP**: on `m_valid_data_out=1`:
  - capture `m_data_out` into `resp_data`
  - set `resp_err=0`
  - go to RESPOND.
- **Timeout**:
  - The timer increments every enabled cycle in ISSUE and WAIT_RESP.
  - When the timer equals `TIMEOUT_CYCLES-1` and the transaction has not completed, set `m_valid_data_in=0`, `resp_data=0` and `resp_err=1`, then go to RESPOND.
  - If completion and timeout fall in the same cycle, completion wins.
- **RESPOND**:
  - Pulse `resp_valid[g]` for one cycle.
  - Set `last_grant=g`, clear `m_cs_sel`, and go to IDLE.
  - `resp_data`, `resp_err` and `grant_id` hold until the next response or grant.
- `m_valid_data_out` is ignored outside WAIT_RESP.
- `req_valid` is not sampled outside IDLE.
- Requester protocol: hold `req_valid` and `req_data`/`req_cs` stable until `req_ready` is seen. Deassert `req_valid` or present the next word in the cycle after `req_ready`.
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_err=0`, `m_data_in=0`, `m_valid_data_in=0`, `m_cs_sel=0`, `busy=0`, `grant_id=0`. State resets to IDLE and `last_grant` to `NUM_REQ-1`, so requester 0 has first priority.
- Reset mid-transaction drops the transaction silently; no response is issued.

## Timing
- Request to acceptance: IDLE sees `req_valid` in cycle T. `req_ready[g]`, `m_valid_data_in`, `busy` and state ISSUE are all active in T+1.
- Issue handshake: `m_ready=1` in cycle A means `m_valid_data_in=0` and state WAIT_RESP in A+1. The minimum is A=T+1.
- Response: `m_valid_data_out` in cycle R means `resp_valid[g]`, `resp_data` and state RESPOND in R+1, and IDLE in R+2.
- Back-to-back: the next grant is sampled at R+2, with `req_ready` at R+3.
- Timeout: the error response appears exactly `TIMEOUT_CYCLES` enabled cycles after entering ISSUE.

## Test plan
- **Single request:** only `req_valid[2]` set, `req_data[2]=16'hA5A5`, `req_cs[2]=1`. The master model asserts `m_ready` at once and returns `16'h3C3C` 5 cycles later. Expected:
  - `req_ready=4'b0100` for 1 cycle
  - `m_data_in=16'hA5A5`, `m_cs_sel=1`
  - `resp_valid=4'b0100`, `resp_data=16'h3C3C`, `resp_err=0`.
- **Round-robin:** all 4 requesters hold `req_valid` for 8 transactions. Expected grant order is 0,1,2,3,0,1,2,3, with no requester granted twice in a row while others wait.
- **Timeout:** `TIMEOUT_CYCLES=8`, master never responds. Expected `resp_valid[g]` with `resp_err=1` and `resp_data=0` exactly 8 cycles after ISSUE entry, then IDLE. A later request completes normally.
- **Stall in ISSUE:** `m_ready` held low for 3 cycles. Expected `m_valid_data_in` and `m_data_in` stable throughout, and a single issue once `m_ready=1`.
- **clk_en gating and spurious response:** `clk_en` toggled 1/0 during WAIT_RESP, plus one `m_valid_data_out` pulse while IDLE. Expected:
  - the FSM and timer freeze on `clk_en=0` cycles
  - the IDLE pulse produces no `resp_valid`.
- **Reset mid-operation:** `rst_n` asserted in WAIT_RESP. Expected all outputs 0 and no response. After release, requester 0 has priority.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that shares a single spi_master parallel
// port between NUM_REQ requesters. It issues one word at a time, waits for
// the returned word (bounded by a timeout) and routes the response back to
// the requester that was granted.
`timescale 1ns/1ps
module spi_arbiter #(
   parameter int NUM_REQ          = 4,
   parameter int DATA_WIDTH       = 16,
   parameter int CHIP_SELECT_SIZE = 1,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  clk_en,
   input  logic [NUM_REQ-1:0]                    req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_data,
   input  logic [NUM_REQ*CHIP_SELECT_SIZE-1:0]   req_cs,
   output logic [NUM_REQ-1:0]                    req_ready,
   output logic [NUM_REQ-1:0]                    resp_valid,
   output logic [DATA_WIDTH-1:0]                 resp_data,
   output logic                                  resp_err,
   output logic [DATA_WIDTH-1:0]                 m_data_in,
   output logic                                  m_valid_data_in,
   input  logic                                  m_ready,
   input  logic [DATA_WIDTH-1:0]                 m_data_out,
   input  logic                                  m_valid_data_out,
   output logic [CHIP_SELECT_SIZE-1:0]           m_cs_sel,
   output logic                                  busy,
   output logic [$clog2(NUM_REQ)-1:0]            grant_id
);

   localparam int GW = $clog2(NUM_REQ);
   // One extra bit so the timer can step one past the limit without wrapping
   // (happens when m_ready arrives exactly on the last ISSUE cycle).
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      RESPOND   = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [GW-1:0]               last_grant_q, last_grant_d;
   logic [GW-1:0]               grant_id_q, grant_id_d;
   logic [TW-1:0]               timer_q, timer_d;
   logic [NUM_REQ-1:0]          req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]       resp_data_q, resp_data_d;
   logic                        resp_err_q, resp_err_d;
   logic [DATA_WIDTH-1:0]       m_data_in_q, m_data_in_d;
   logic                        m_valid_q, m_valid_d;
   logic [CHIP_SELECT_SIZE-1:0] m_cs_sel_q, m_cs_sel_d;
   logic                        busy_q, busy_d;

   // Unpacked views of the flat per-requester buses.
   logic [DATA_WIDTH-1:0]       req_word [NUM_REQ];
   logic [CHIP_SELECT_SIZE-1:0] req_sel  [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign req_sel[gi]  = req_cs[gi*CHIP_SELECT_SIZE +: CHIP_SELECT_SIZE];
      end
   endgenerate

   logic          pick_found;
   logic [GW-1:0] pick_idx;
   logic          timeout_hit;

   assign timeout_hit = (timer_q >= TW'(TIMEOUT_CYCLES - 1));

   // Round-robin pick: scan offsets from the far end back toward last_grant+1
   // so the nearest pending requester after the last grant overwrites the rest.
   always_comb begin
      int cand;
      cand       = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = int'(last_grant_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (req_valid[GW'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = GW'(cand);
         end
      end
   end

   // Next-state and next-output computation for the transaction sequencer.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      timer_d      = timer_q;
      req_ready_d  = '0;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      m_data_in_d  = m_data_in_q;
      m_valid_d    = m_valid_q;
      m_cs_sel_d   = m_cs_sel_q;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_id_d            = pick_idx;
               req_ready_d[pick_idx] = 1'b1;
               m_data_in_d           = req_word[pick_idx];
               m_cs_sel_d            = req_sel[pick_idx];
               m_valid_d             = 1'b1;
               timer_d               = '0;
               state_d               = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = timer_q + TW'(1);
            // Acceptance by the master beats a coincident timeout.
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = WAIT_RESP;
            end else if (timeout_hit) begin
               m_valid_d                = 1'b0;
               resp_data_d              = '0;
               resp_err_d               = 1'b1;
               resp_valid_d[grant_id_q] = 1'b1;
               state_d                  = RESPOND;
            end
         end
         WAIT_RESP: begin
            timer_d = timer_q + TW'(1);
            if (m_valid_data_out) begin
               resp_data_d              = m_data_out;
               resp_err_d               = 1'b0;
               resp_valid_d[grant_id_q] = 1'b1;
               state_d                  = RESPOND;
            end else if (timeout_hit) begin
               m_valid_d                = 1'b0;
               resp_data_d              = '0;
               resp_err_d               = 1'b1;
               resp_valid_d[grant_id_q] = 1'b1;
               state_d                  = RESPOND;
            end
         end
         RESPOND: begin
            last_grant_d = grant_id_q;
            m_cs_sel_d   = '0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; everything holds while clk_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= GW'(NUM_REQ - 1);
         grant_id_q   <= '0;
         timer_q      <= '0;
         req_ready_q  <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         m_data_in_q  <= '0;
         m_valid_q    <= 1'b0;
         m_cs_sel_q   <= '0;
         busy_q       <= 1'b0;
      end else if (clk_en) begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         timer_q      <= timer_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         m_data_in_q  <= m_data_in_d;
         m_valid_q    <= m_valid_d;
         m_cs_sel_q   <= m_cs_sel_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ready       = req_ready_q;
   assign resp_valid      = resp_valid_q;
   assign resp_data       = resp_data_q;
   assign resp_err        = resp_err_q;
   assign m_data_in       = m_data_in_q;
   assign m_valid_data_in = m_valid_q;
   assign m_cs_sel        = m_cs_sel_q;
   assign busy            = busy_q;
   assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (4 requesters, 16-bit words,
// timeout of 8 enabled cycles).
`timescale 1ns/1ps
module tb_spi_arbiter;

   logic        clk;
   logic        rst_n;
   logic        clk_en;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_cs;
   logic [3:0]  req_ready;
   logic [3:0]  resp_valid;
   logic [15:0] resp_data;
   logic        resp_err;
   logic [15:0] m_data_in;
   logic        m_valid_data_in;
   logic        m_ready;
   logic [15:0] m_data_out;
   logic        m_valid_data_out;
   logic [0:0]  m_cs_sel;
   logic        busy;
   logic [1:0]  grant_id;

   int n_assert = 0;
   int n_fail   = 0;

   spi_arbiter #(
      .NUM_REQ          (4),
      .DATA_WIDTH       (16),
      .CHIP_SELECT_SIZE (1),
      .TIMEOUT_CYCLES   (8)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .clk_en           (clk_en),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_cs           (req_cs),
      .req_ready        (req_ready),
      .resp_valid       (resp_valid),
      .resp_data        (resp_data),
      .resp_err         (resp_err),
      .m_data_in        (m_data_in),
      .m_valid_data_in  (m_valid_data_in),
      .m_ready          (m_ready),
      .m_data_out       (m_data_out),
      .m_valid_data_out (m_valid_data_out),
      .m_cs_sel         (m_cs_sel),
      .busy             (busy),
      .grant_id         (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [15:0] w, input logic c);
      req_data[i*16 +: 16] = w;
      req_cs[i]            = c;
   endtask

   task automatic wait_grant();
      int n = 0;
      while (req_ready == 4'b0000 && n < 16) begin
         tick();
         n++;
      end
      check("grant_seen", (req_ready != 4'b0000), 1);
   endtask

   // Full transaction: grant, optional issue stall, response after resp_delay.
   task automatic serve(input int g, input logic [15:0] word, input logic cs,
                        input int ready_delay, input int resp_delay,
                        input logic [15:0] rword, input bit drop);
      wait_grant();
      check("grant_id", grant_id, g);
      check("req_ready", req_ready, 64'd1 << g);
      check("m_data_in", m_data_in, word);
      check("m_cs_sel", m_cs_sel, cs);
      check("m_valid_issue", m_valid_data_in, 1);
      check("busy_issue", busy, 1);
      if (drop) req_valid[g] = 1'b0;
      for (int i = 0; i < ready_delay; i++) begin
         m_ready = 1'b0;
         tick();
         check("stall_m_valid", m_valid_data_in, 1);
         check("stall_m_data_in", m_data_in, word);
         check("stall_req_ready", req_ready, 0);
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("m_valid_dropped", m_valid_data_in, 0);
      check("req_ready_pulse", req_ready, 0);
      for (int i = 0; i < resp_delay; i++) begin
         tick();
         check("wait_no_resp", resp_valid, 0);
         check("wait_no_reissue", m_valid_data_in, 0);
      end
      m_valid_data_out = 1'b1;
      m_data_out       = rword;
      tick();
      m_valid_data_out = 1'b0;
      check("resp_valid", resp_valid, 64'd1 << g);
      check("resp_data", resp_data, rword);
      check("resp_err", resp_err, 0);
      tick();
      check("resp_pulse_end", resp_valid, 0);
      check("busy_idle", busy, 0);
      check("m_cs_sel_cleared", m_cs_sel, 0);
      check("resp_data_hold", resp_data, rword);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_resp_data"}, resp_data, 0);
      check({tag, "_resp_err"}, resp_err, 0);
      check({tag, "_m_data_in"}, m_data_in, 0);
      check({tag, "_m_valid"}, m_valid_data_in, 0);
      check({tag, "_m_cs_sel"}, m_cs_sel, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_grant_id"}, grant_id, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n            = 1'b0;
      clk_en           = 1'b1;
      req_valid        = 4'b0000;
      req_data         = '0;
      req_cs           = 4'b0000;
      m_ready          = 1'b0;
      m_data_out       = '0;
      m_valid_data_out = 1'b0;

      do_reset();

      // Single request from requester 2.
      set_req(2, 16'hA5A5, 1'b1);
      req_valid = 4'b0100;
      serve(2, 16'hA5A5, 1'b1, 0, 4, 16'h3C3C, 1);
      $display("single: requester 2 served");

      // Round-robin with all four requesters pending.
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 16'h1000 + 16'(i), i[0]);
      req_valid = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         serve(j % 4, 16'h1000 + 16'(j % 4), 1'((j % 4) & 1), 0, 1, 16'hB000 + 16'(j), 0);
         $display("round-robin: transaction %0d expected grant %0d", j, j % 4);
      end
      req_valid = 4'b0000;

      // Timeout: master accepts but never responds.
      set_req(1, 16'h5A5A, 1'b1);
      req_valid = 4'b0010;
      wait_grant();
      check("to_grant_id", grant_id, 1);
      req_valid = 4'b0000;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("to_m_valid", m_valid_data_in, 0);
      repeat (6) tick();
      check("to_not_early", resp_valid, 0);
      check("to_busy", busy, 1);
      tick();
      check("to_resp_valid", resp_valid, 4'b0010);
      check("to_resp_err", resp_err, 1);
      check("to_resp_data", resp_data, 0);
      tick();
      check("to_idle_busy", busy, 0);
      check("to_pulse_end", resp_valid, 0);
      $display("timeout: requester 1 timed out");

      // Requests after the timeout, including wrap-around from 3 to 0.
      set_req(0, 16'h0F0F, 1'b0);
      set_req(3, 16'hF0F0, 1'b1);
      req_valid = 4'b1001;
      serve(3, 16'hF0F0, 1'b1, 0, 1, 16'h2222, 1);
      serve(0, 16'h0F0F, 1'b0, 0, 1, 16'h3333, 1);
      $display("post-timeout: requesters 3 and 0 served");

      // Stall in ISSUE for 3 cycles.
      set_req(2, 16'hC0DE, 1'b0);
      req_valid = 4'b0100;
      serve(2, 16'hC0DE, 1'b0, 3, 1, 16'h7777, 1);
      $display("stall: requester 2 served after 3-cycle stall");

      // clk_en gating during WAIT_RESP.
      set_req(1, 16'h1234, 1'b1);
      req_valid = 4'b0010;
      wait_grant();
      check("cen_grant_id", grant_id, 1);
      req_valid = 4'b0000;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("cen_m_valid", m_valid_data_in, 0);
      clk_en = 1'b0;
      repeat (10) tick();
      m_valid_data_out = 1'b1;
      m_data_out       = 16'hDEAD;
      tick();
      m_valid_data_out = 1'b0;
      check("cen_frozen_resp", resp_valid, 0);
      check("cen_frozen_busy", busy, 1);
      for (int i = 0; i < 2; i++) begin
         clk_en = 1'b1;
         tick();
         clk_en = 1'b0;
         tick();
      end
      check("cen_toggle_resp", resp_valid, 0);
      clk_en           = 1'b1;
      m_valid_data_out = 1'b1;
      m_data_out       = 16'h4321;
      tick();
      m_valid_data_out = 1'b0;
      check("cen_resp_valid", resp_valid, 4'b0010);
      check("cen_resp_data", resp_data, 16'h4321);
      check("cen_resp_err", resp_err, 0);
      clk_en = 1'b0;
      tick();
      check("cen_stretch", resp_valid, 4'b0010);
      clk_en = 1'b1;
      tick();
      check("cen_pulse_end", resp_valid, 0);
      check("cen_idle", busy, 0);
      $display("clk_en: response delivered after gated wait");

      // Spurious master response while IDLE.
      m_valid_data_out = 1'b1;
      m_data_out       = 16'hBAD0;
      tick();
      m_valid_data_out = 1'b0;
      check("spur_resp_valid", resp_valid, 0);
      check("spur_busy", busy, 0);
      tick();
      check("spur_resp_valid2", resp_valid, 0);
      check("spur_resp_data", resp_data, 16'h4321);
      $display("spurious: idle response ignored");

      // Reset in WAIT_RESP.
      set_req(2, 16'h9999, 1'b1);
      req_valid = 4'b0100;
      wait_grant();
      check("rst_grant_id", grant_id, 2);
      req_valid = 4'b0000;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      m_valid_data_out = 1'b1;
      m_data_out       = 16'h5555;
      tick();
      tick();
      m_valid_data_out = 1'b0;
      check("midrst_no_resp", resp_valid, 0);
      rst_n = 1'b1;
      tick();
      check("midrst_idle_resp", resp_valid, 0);
      set_req(0, 16'hAAAA, 1'b0);
      set_req(3, 16'hBBBB, 1'b1);
      req_valid = 4'b1001;
      serve(0, 16'hAAAA, 1'b0, 0, 1, 16'h1111, 1);
      serve(3, 16'hBBBB, 1'b1, 0, 1, 16'h4444, 1);
      $display("reset: requester 0 first after mid-transaction reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
